// File: rtl/regfile_writeback_if.sv
// ---------------------------------------------------------------------------
// regfile_writeback_if
// Bundles every signal of the register-file write-back block apart from its
// clock and reset.
//
// Ports / members:
//   issue    : iss_valid, iss_rd -> iss_ready   (destination reservation)
//   query    : chk_r0, chk_r1    -> busy0, busy1 (source hazard check)
//   alu      : alu_valid, alu_rd, alu_data -> alu_ready
//   mem      : mem_valid, mem_rd, mem_data -> mem_ready
//   file     : rd, data          (register file write port, rd == 0 is no write)
//   status   : err               (sticky protocol error)
//   bypass   : fwd0, fwd1, fwd_data (present only with REGWB_BYPASS_EN)
//
// Handshake: a channel transfers when valid && ready are both high at a
// rising clock edge; the producer holds valid, rd and data until then.
//
// Modports: slave = the write-back block, master = the issue stage and the
// result producers that drive it.
//
// Optional feature macro: REGWB_BYPASS_EN
// ---------------------------------------------------------------------------
interface regfile_writeback_if #(
    parameter int WIDTH = 16
);
    logic             iss_valid;
    logic [4:0]       iss_rd;
    logic             iss_ready;
    logic [4:0]       chk_r0;
    logic [4:0]       chk_r1;
    logic             busy0;
    logic             busy1;
    logic             alu_valid;
    logic [4:0]       alu_rd;
    logic [WIDTH-1:0] alu_data;
    logic             alu_ready;
    logic             mem_valid;
    logic [4:0]       mem_rd;
    logic [WIDTH-1:0] mem_data;
    logic             mem_ready;
    logic [4:0]       rd;
    logic [WIDTH-1:0] data;
    logic             err;
`ifdef REGWB_BYPASS_EN
    logic             fwd0;
    logic             fwd1;
    logic [WIDTH-1:0] fwd_data;

    modport slave (
        input  iss_valid, iss_rd, chk_r0, chk_r1,
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output iss_ready, busy0, busy1, alu_ready, mem_ready,
        output rd, data, err, fwd0, fwd1, fwd_data
    );

    modport master (
        output iss_valid, iss_rd, chk_r0, chk_r1,
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  iss_ready, busy0, busy1, alu_ready, mem_ready,
        input  rd, data, err, fwd0, fwd1, fwd_data
    );
`else
    modport slave (
        input  iss_valid, iss_rd, chk_r0, chk_r1,
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output iss_ready, busy0, busy1, alu_ready, mem_ready,
        output rd, data, err
    );

    modport master (
        output iss_valid, iss_rd, chk_r0, chk_r1,
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  iss_ready, busy0, busy1, alu_ready, mem_ready,
        input  rd, data, err
    );
`endif
endinterface

// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback
// Write-side companion to the 32-entry register file. Arbitrates ALU and
// load-unit results onto the file's single write port and keeps a busy-bit
// scoreboard of in-flight destinations so issue can stall on RAW/WAW hazards.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : regfile_writeback_if.slave (issue, query, alu, mem, file, err)
//
// Behaviour summary:
//   - Load unit has fixed priority: mem_ready = 1, alu_ready = !mem_valid.
//   - An accepted result appears on rd/data for exactly one cycle; with no
//     accepted result rd = 0 and data holds.
//   - busy[rd] drops at the edge that ends the rd cycle, since the file
//     captures data at that same edge; a same-edge reservation wins.
//
// Optional feature macro: REGWB_BYPASS_EN
//   When defined, a source matching the register currently being written
//   reports not-busy and raises fwd0/fwd1, with fwd_data carrying the value.
// ---------------------------------------------------------------------------
module regfile_writeback #(
    parameter int WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst,
    regfile_writeback_if.slave   bus
);
    localparam logic [4:0] R_ZERO = 5'd0;

    logic [31:0]      r_busy;
    logic [4:0]       r_rd;
    logic [WIDTH-1:0] r_data;
    logic             r_err;

    logic             w_mem_acc;
    logic             w_alu_acc;
    logic             w_acc;
    logic [4:0]       w_acc_rd;
    logic [WIDTH-1:0] w_acc_data;
    logic             w_iss_ready;
    logic             w_iss_set;
    logic             w_res_err;
    logic             w_iss_err;
    logic [31:0]      w_busy_nxt;
    logic             w_fwd0;
    logic             w_fwd1;

    always_comb begin
        // Loads cannot be back-pressured, so the ALU only gets idle cycles.
        w_mem_acc  = bus.mem_valid;
        w_alu_acc  = bus.alu_valid && !bus.mem_valid;
        w_acc      = w_mem_acc || w_alu_acc;
        w_acc_rd   = w_mem_acc ? bus.mem_rd   : bus.alu_rd;
        w_acc_data = w_mem_acc ? bus.mem_data : bus.alu_data;

        w_iss_ready = (bus.iss_rd == R_ZERO) || !r_busy[bus.iss_rd];
        w_iss_set   = bus.iss_valid && w_iss_ready && (bus.iss_rd != R_ZERO);

        // A result for a register nobody reserved, or an issue that ignores
        // a stall, both indicate a broken producer.
        w_res_err = w_acc && (w_acc_rd != R_ZERO) && !r_busy[w_acc_rd];
        w_iss_err = bus.iss_valid && !w_iss_ready;

        // Clear first, then set, so a reservation landing on the edge that
        // retires the previous write of the same register survives.
        w_busy_nxt = r_busy;
        if (r_rd != R_ZERO) begin
            w_busy_nxt[r_rd] = 1'b0;
        end
        if (w_iss_set) begin
            w_busy_nxt[bus.iss_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;

`ifdef REGWB_BYPASS_EN
        w_fwd0 = (bus.chk_r0 == r_rd) && (r_rd != R_ZERO);
        w_fwd1 = (bus.chk_r1 == r_rd) && (r_rd != R_ZERO);
`else
        w_fwd0 = 1'b0;
        w_fwd1 = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_rd   <= R_ZERO;
            r_data <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_err  <= r_err || w_res_err || w_iss_err;
            // Results to r0 are consumed but never reach the write port.
            if (w_acc && (w_acc_rd != R_ZERO)) begin
                r_rd   <= w_acc_rd;
                r_data <= w_acc_data;
            end else begin
                r_rd   <= R_ZERO;
            end
        end
    end

    assign bus.mem_ready = 1'b1;
    assign bus.alu_ready = !bus.mem_valid;
    assign bus.iss_ready = w_iss_ready;
    assign bus.busy0     = r_busy[bus.chk_r0] && !w_fwd0;
    assign bus.busy1     = r_busy[bus.chk_r1] && !w_fwd1;
    assign bus.rd        = r_rd;
    assign bus.data      = r_data;
    assign bus.err       = r_err;

`ifdef REGWB_BYPASS_EN
    assign bus.fwd0     = w_fwd0;
    assign bus.fwd1     = w_fwd1;
    assign bus.fwd_data = r_data;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback
// Self-checking bench for regfile_writeback. Inputs change on the falling
// edge, outputs are compared 1 ns later against a reference model that
// tracks the set of reserved registers and a queue of writes owed to the
// register file. Directed scenarios run first, then randomized traffic.
// Build with +define+REGWB_BYPASS_EN to also cover the bypass outputs.
// ---------------------------------------------------------------------------
module tb_regfile_writeback;
    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_writeback_if #(.WIDTH(W)) bus ();

    regfile_writeback #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model ----------------
    bit                m_busy[32];   // registers reserved and not yet written
    bit                m_err;
    logic [5+W-1:0]    exp_q[$];     // {rd, data} owed to the file next cycle
    logic [4:0]        pend[$];      // reserved registers without a producer yet
    bit                alu_done;     // ALU offer was consumed at the last edge

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_err = 1'b0;
        exp_q.delete();
        pend.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
        bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = 5'd0; bus.mem_data = '0;
    endtask

    // Compare all outputs for the current cycle, then advance the model over
    // the next rising edge. Called with the clock low.
    task automatic tick();
        bit             has;
        logic [4:0]     cur_rd;
        logic [W-1:0]   cur_data;
        bit             exp_ready;
        bit             byp0, byp1;
        bit             acc;
        logic [4:0]     acc_rd;
        logic [W-1:0]   acc_data;

        #1;
        has      = (exp_q.size() != 0);
        cur_rd   = has ? exp_q[0][5+W-1:W] : 5'd0;
        cur_data = has ? exp_q[0][W-1:0]   : '0;
        exp_ready = (bus.iss_rd == 5'd0) || !m_busy[bus.iss_rd];
`ifdef REGWB_BYPASS_EN
        byp0 = has && (bus.chk_r0 == cur_rd);
        byp1 = has && (bus.chk_r1 == cur_rd);
`else
        byp0 = 1'b0;
        byp1 = 1'b0;
`endif
        check("rd",        32'(bus.rd),        32'(cur_rd));
        if (has) check("data", 32'(bus.data),  32'(cur_data));
        check("err",       32'(bus.err),       32'(m_err));
        check("iss_ready", 32'(bus.iss_ready), 32'(exp_ready));
        check("mem_ready", 32'(bus.mem_ready), 32'(1));
        check("alu_ready", 32'(bus.alu_ready), 32'(!bus.mem_valid));
        check("busy0",     32'(bus.busy0),     32'(m_busy[bus.chk_r0] && !byp0));
        check("busy1",     32'(bus.busy1),     32'(m_busy[bus.chk_r1] && !byp1));
`ifdef REGWB_BYPASS_EN
        check("fwd0",      32'(bus.fwd0),      32'(byp0));
        check("fwd1",      32'(bus.fwd1),      32'(byp1));
        if (has) check("fwd_data", 32'(bus.fwd_data), 32'(cur_data));
`endif

        @(posedge clk);
        if (rst) begin
            model_reset();
            alu_done = 1'b1;
        end else begin
            acc      = bus.mem_valid || bus.alu_valid;
            acc_rd   = bus.mem_valid ? bus.mem_rd   : bus.alu_rd;
            acc_data = bus.mem_valid ? bus.mem_data : bus.alu_data;
            alu_done = bus.alu_valid && !bus.mem_valid;
            if (acc && acc_rd != 5'd0 && !m_busy[acc_rd]) m_err = 1'b1;
            if (bus.iss_valid && !exp_ready) m_err = 1'b1;
            if (has) begin
                m_busy[cur_rd] = 1'b0;
                void'(exp_q.pop_front());
            end
            if (bus.iss_valid && exp_ready && bus.iss_rd != 5'd0) begin
                m_busy[bus.iss_rd] = 1'b1;
                pend.push_back(bus.iss_rd);
            end
            if (acc && acc_rd != 5'd0) exp_q.push_back({acc_rd, acc_data});
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [4:0] r);
        idle();
        bus.iss_valid = 1'b1; bus.iss_rd = r;
        tick();
        idle();
    endtask

    task automatic sweep_idle();
        idle();
        for (int i = 0; i < 32; i++) begin
            bus.chk_r0 = 5'(i);
            bus.chk_r1 = 5'(31 - i);
            tick();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        bus.chk_r0 = 5'd0; bus.chk_r1 = 5'd0;
        model_reset();
        alu_done = 1'b1;
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;

        // Reset state: nothing busy, no write, no error.
        check("rst_data", 32'(bus.data), 32'(0));
        sweep_idle();

        // Single ALU round trip to r5.
        bus.chk_r0 = 5'd5; bus.chk_r1 = 5'd0;
        issue(5'd5);
        tick(); tick();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 16'h1234;
        tick();
        idle();
        check("r5_busy_in_wr_cycle", 32'(bus.busy0), 32'(m_busy[5] && (`ifdef REGWB_BYPASS_EN 1'b0 `else 1'b1 `endif)));
        tick(); tick();

        // Load and ALU collide: load first, ALU next cycle.
        bus.chk_r0 = 5'd3; bus.chk_r1 = 5'd4;
        issue(5'd3);
        issue(5'd4);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 16'h0333;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 16'h0444;
        tick();
        bus.mem_valid = 1'b0;
        tick();
        idle();
        tick(); tick();

        // Bypass view of a write in flight.
        bus.chk_r0 = 5'd2; bus.chk_r1 = 5'd2;
        issue(5'd2);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 16'hBEEF;
        tick();
        idle();
        tick(); tick();

        // Result to r0 is discarded quietly.
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 16'hDEAD;
        tick();
        idle();
        tick();

        // Protocol errors: WAW issue, then a result nobody reserved.
        bus.chk_r0 = 5'd7; bus.chk_r1 = 5'd9;
        issue(5'd7);
        issue(5'd7);
        tick();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 16'h0999;
        tick();
        idle();
        for (int i = 0; i < 4; i++) tick();

        // Reset one cycle after accepting a result for r6.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.chk_r0 = 5'd6; bus.chk_r1 = 5'd6;
        issue(5'd6);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 16'h0666;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rd_after_midop_rst", 32'(bus.rd), 32'(0));
        sweep_idle();

        // Randomized legal traffic.
        for (int c = 0; c < 1500; c++) begin
            int idx;
            bus.iss_rd    = 5'($urandom_range(31));
            bus.iss_valid = ($urandom_range(1) == 1) && !m_busy[bus.iss_rd];
            bus.chk_r0    = 5'($urandom_range(31));
            bus.chk_r1    = 5'($urandom_range(31));

            bus.mem_valid = 1'b0;
            if (pend.size() != 0 && $urandom_range(3) == 0) begin
                idx = int'($urandom_range(pend.size() - 1));
                bus.mem_valid = 1'b1;
                bus.mem_rd    = pend[idx];
                bus.mem_data  = W'($urandom);
                pend.delete(idx);
            end else if ($urandom_range(15) == 0) begin
                bus.mem_valid = 1'b1;
                bus.mem_rd    = 5'd0;
                bus.mem_data  = W'($urandom);
            end

            // A held ALU offer keeps its rd/data until accepted.
            if (!(bus.alu_valid && !alu_done)) begin
                bus.alu_valid = 1'b0;
                if (pend.size() != 0 && $urandom_range(1) == 0) begin
                    idx = int'($urandom_range(pend.size() - 1));
                    bus.alu_valid = 1'b1;
                    bus.alu_rd    = pend[idx];
                    bus.alu_data  = W'($urandom);
                    pend.delete(idx);
                end
            end
            tick();
        end
        idle();
        tick(); tick(); tick();

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
